// File: rtl/audio_dac_sd.sv
// First-order sigma-delta audio DAC.
// A 16-bit signed sample is taken through a one-deep holding register. On each
// divider tick it is rounded and saturated to BIT_WIDTH bits, then converted to
// offset binary to form the active code. The accumulator carry is the
// one-bit output stream.
module audio_dac_sd #(
  parameter int BIT_WIDTH = 10,
  parameter int FREQ_DIV  = 5
) (
  input  logic        CLK,
  input  logic        RESET_n,
  input  logic        ENABLE,
  input  logic [15:0] SAMPLE,
  input  logic        SAMPLE_VALID,
  output logic        SAMPLE_READY,
  output logic        DAC_OUT,
  output logic        CLIP
);

  localparam int SHIFT = 16 - BIT_WIDTH;
  localparam logic signed [16:0] ROUND  = 17'(1 << (15 - BIT_WIDTH));
  localparam logic signed [16:0] LIM_HI = 17'((1 << (BIT_WIDTH - 1)) - 1);
  localparam logic signed [16:0] LIM_LO = ~LIM_HI;
  localparam logic [BIT_WIDTH-1:0] SAT_HI = {1'b0, {(BIT_WIDTH-1){1'b1}}};
  localparam logic [BIT_WIDTH-1:0] SAT_LO = {1'b1, {(BIT_WIDTH-1){1'b0}}};
  localparam logic [BIT_WIDTH-1:0] MID    = {1'b1, {(BIT_WIDTH-1){1'b0}}};
  localparam logic [7:0] DIV_LAST = 8'(FREQ_DIV - 1);

  logic [7:0]           cnt_q, cnt_d;
  logic                 full_q, full_d;
  logic [15:0]          hold_q, hold_d;
  logic [BIT_WIDTH-1:0] code_q, code_d;
  logic [BIT_WIDTH:0]   acc_q, acc_d;
  logic                 dac_q, dac_d;
  logic                 clip_q, clip_d;

  logic                 tick;
  logic                 transfer;
  logic                 load;
  logic signed [16:0]   sum17;
  logic signed [16:0]   shifted;
  logic [BIT_WIDTH-1:0] sat;
  logic                 sat_hit;
  logic [BIT_WIDTH-1:0] q_code;

  assign tick         = (cnt_q == DIV_LAST);
  assign SAMPLE_READY = !ENABLE || !full_q || tick;
  assign transfer     = ENABLE && SAMPLE_VALID && SAMPLE_READY;
  assign load         = ENABLE && tick && full_q;
  assign DAC_OUT      = dac_q;
  assign CLIP         = clip_q;

  // Round-to-nearest, arithmetic shift, saturate, then flip MSB to offset binary.
  always_comb begin
    sum17   = $signed({hold_q[15], hold_q}) + ROUND;
    shifted = sum17 >>> SHIFT;
    sat     = shifted[BIT_WIDTH-1:0];
    sat_hit = 1'b0;
    if (shifted > LIM_HI) begin
      sat     = SAT_HI;
      sat_hit = 1'b1;
    end else if (shifted < LIM_LO) begin
      sat     = SAT_LO;
      sat_hit = 1'b1;
    end
    q_code = {~sat[BIT_WIDTH-1], sat[BIT_WIDTH-2:0]};
  end

  // Next-state: divider, holding register handshake, code load/mute, modulator.
  always_comb begin
    cnt_d  = tick ? 8'd0 : cnt_q + 8'd1;
    full_d = full_q;
    hold_d = hold_q;
    code_d = code_q;
    acc_d  = acc_q;
    dac_d  = dac_q;
    clip_d = 1'b0;
    if (!ENABLE) begin
      // Muted: offered samples are swallowed and the output settles to midscale.
      full_d = 1'b0;
      if (tick) code_d = MID;
    end else begin
      if (load) begin
        code_d = q_code;
        full_d = 1'b0;
        clip_d = sat_hit;
      end
      // A transfer on the load tick refills the holding register immediately.
      if (transfer) begin
        hold_d = SAMPLE;
        full_d = 1'b1;
      end
    end
    // The modulator integrates the code that was active before this tick.
    if (tick) begin
      acc_d = {1'b0, acc_q[BIT_WIDTH-1:0]} + {1'b0, code_q};
      dac_d = acc_d[BIT_WIDTH];
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge CLK) begin
    if (!RESET_n) begin
      cnt_q  <= 8'd0;
      full_q <= 1'b0;
      hold_q <= 16'd0;
      code_q <= MID;
      acc_q  <= '0;
      dac_q  <= 1'b0;
      clip_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      full_q <= full_d;
      hold_q <= hold_d;
      code_q <= code_d;
      acc_q  <= acc_d;
      dac_q  <= dac_d;
      clip_q <= clip_d;
    end
  end

endmodule

// File: tb/tb_audio_dac_sd.sv
// Self-checking bench for audio_dac_sd (BIT_WIDTH=10, FREQ_DIV=5).
module tb_audio_dac_sd;
  localparam int BW = 10;
  localparam int FD = 5;

  logic        CLK = 1'b0;
  logic        RESET_n = 1'b0;
  logic        ENABLE = 1'b0;
  logic [15:0] SAMPLE = 16'd0;
  logic        SAMPLE_VALID = 1'b0;
  logic        SAMPLE_READY;
  logic        DAC_OUT;
  logic        CLIP;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [15:0] sample;
    int          code;
    bit          clip;
  } vec_t;

  vec_t vecs[8];
  vec_t sb[$];

  int   tb_div = 0;
  bit   last_tick = 1'b0;
  bit   last_rst = 1'b0;
  bit   mon_en = 1'b0;
  logic dac_prev = 1'b0;

  audio_dac_sd #(.BIT_WIDTH(BW), .FREQ_DIV(FD)) dut (
    .CLK(CLK),
    .RESET_n(RESET_n),
    .ENABLE(ENABLE),
    .SAMPLE(SAMPLE),
    .SAMPLE_VALID(SAMPLE_VALID),
    .SAMPLE_READY(SAMPLE_READY),
    .DAC_OUT(DAC_OUT),
    .CLIP(CLIP)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference tick timing: divider 0..FD-1, cleared by reset.
  always @(posedge CLK) begin
    last_tick <= (tb_div == FD - 1);
    last_rst  <= !RESET_n;
    if (!RESET_n) tb_div <= 0;
    else tb_div <= (tb_div == FD - 1) ? 0 : tb_div + 1;
  end

  // DAC_OUT may only move on a tick edge (or a reset edge).
  always @(negedge CLK) begin
    if (mon_en && !last_tick && !last_rst) check("dac_hold", DAC_OUT, dac_prev);
    dac_prev = DAC_OUT;
  end

  // Called at a negedge; returns at the negedge just after the next tick edge.
  task automatic tick_edge();
    while (tb_div != FD - 1) @(negedge CLK);
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic count_ones(input int n, output int ones);
    ones = 0;
    repeat (n) begin
      tick_edge();
      ones += int'(DAC_OUT);
    end
  endtask

  task automatic startup_pattern(input string name);
    logic exp;
    for (int e = 1; e <= 20; e++) begin
      @(negedge CLK);
      exp = ((e / FD) >= 2) && ((e / FD) % 2 == 0);
      check({name, "_dac"}, DAC_OUT, exp);
      check({name, "_clip"}, CLIP, 0);
    end
  endtask

  task automatic play(input vec_t v);
    int   waited;
    int   ones;
    vec_t e;
    waited = 0;
    SAMPLE = v.sample;
    SAMPLE_VALID = 1'b1;
    while (SAMPLE_READY !== 1'b1 && waited < 20) begin
      @(negedge CLK);
      waited++;
    end
    if (SAMPLE_READY !== 1'b1) begin
      check("play_ready_wait", SAMPLE_READY, 1);
      SAMPLE_VALID = 1'b0;
      return;
    end
    @(posedge CLK);
    sb.push_back(v);
    @(negedge CLK);
    SAMPLE_VALID = 1'b0;
    tick_edge();
    e = sb.pop_front();
    check("clip_at_load", CLIP, e.clip);
    @(negedge CLK);
    check("clip_one_cycle", CLIP, 0);
    count_ones(1 << BW, ones);
    check("ones_per_1024", ones, e.code);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tmp;
    vec_t e;
    int   ones;
    int   waited;

    vecs[0] = '{16'h7FFF, 1023, 1'b1};
    vecs[1] = '{16'h8000,    0, 1'b0};
    vecs[2] = '{16'h0040,  513, 1'b0};
    vecs[3] = '{16'hFFE0,  512, 1'b0};
    vecs[4] = '{16'h7FE0, 1023, 1'b1};
    vecs[5] = '{16'h7FDF, 1023, 1'b0};
    vecs[6] = '{16'h1234,  585, 1'b0};
    vecs[7] = '{16'hC000,  256, 1'b0};

    // Reset state and idle midscale pattern
    ENABLE  = 1'b1;
    RESET_n = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_dac", DAC_OUT, 0);
    check("rst_clip", CLIP, 0);
    check("rst_ready", SAMPLE_READY, 1);
    RESET_n = 1'b1;
    mon_en  = 1'b1;
    startup_pattern("idle");

    // Quantisation / saturation table
    for (int i = 0; i < 8; i++) play(vecs[i]);

    // Back-to-back samples A then B between ticks
    tick_edge();
    SAMPLE = 16'h7FFF;
    SAMPLE_VALID = 1'b1;
    check("b2b_ready_a", SAMPLE_READY, 1);
    @(posedge CLK);
    tmp = '{16'h7FFF, 1023, 1'b1};
    sb.push_back(tmp);
    @(negedge CLK);
    SAMPLE = 16'h8000;
    check("b2b_ready_low", SAMPLE_READY, 0);
    waited = 0;
    while (SAMPLE_READY !== 1'b1 && waited < 10) begin
      @(negedge CLK);
      waited++;
    end
    check("b2b_ready_high", SAMPLE_READY, 1);
    check("b2b_ready_on_tick", tb_div, FD - 1);
    @(posedge CLK);
    tmp = '{16'h8000, 0, 1'b0};
    sb.push_back(tmp);
    @(negedge CLK);
    SAMPLE_VALID = 1'b0;
    e = sb.pop_front();
    check("b2b_clip_a", CLIP, e.clip);
    @(negedge CLK);
    check("b2b_clip_once", CLIP, 0);
    tick_edge();
    e = sb.pop_front();
    check("b2b_clip_b", CLIP, e.clip);
    count_ones(16, ones);
    check("b2b_code_b", ones, e.code);

    // Mute with a held sample, then resume
    tick_edge();
    SAMPLE = 16'h7FFF;
    SAMPLE_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    ENABLE = 1'b0;
    #1;
    check("mute_ready", SAMPLE_READY, 1);
    @(negedge CLK);
    SAMPLE_VALID = 1'b0;
    tick_edge();
    check("mute_clip_tick", CLIP, 0);
    @(negedge CLK);
    check("mute_clip_next", CLIP, 0);
    count_ones(16, ones);
    check("mute_midscale", ones, 8);
    ENABLE = 1'b1;
    tmp = '{16'h0040, 513, 1'b0};
    play(tmp);

    // One-cycle reset mid-stream with a held sample
    tick_edge();
    SAMPLE = 16'h7FFF;
    SAMPLE_VALID = 1'b1;
    @(posedge CLK);
    @(negedge CLK);
    SAMPLE_VALID = 1'b0;
    RESET_n = 1'b0;
    @(negedge CLK);
    RESET_n = 1'b1;
    check("mid_rst_dac", DAC_OUT, 0);
    check("mid_rst_clip", CLIP, 0);
    check("mid_rst_ready", SAMPLE_READY, 1);
    startup_pattern("post_rst");

    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/audio_dac_sd.md
AUDIO_DAC_SD -- requirements
Module: audio_dac_sd

Interface
REQ-001 Parameter BIT_WIDTH, default 10, DAC quantisation width in bits; legal range 4..15.
REQ-002 Parameter FREQ_DIV, default 5, CLK cycles per DAC update (tick); legal range 1..255.
REQ-003 CLK  in  1  sole clock; all state changes on rising edge.
REQ-004 RESET_n  in  1  reset, synchronous, active-low.
REQ-005 ENABLE  in  1  1 = play accepted samples; 0 = mute to midscale.
REQ-006 SAMPLE  in  16  signed two's-complement audio sample.
REQ-007 SAMPLE_VALID  in  1  SAMPLE is offered this cycle.
REQ-008 SAMPLE_READY  out  1  block accepts SAMPLE this cycle; transfer = SAMPLE_VALID && SAMPLE_READY.
REQ-009 DAC_OUT  out  1  registered first-order sigma-delta bitstream.
REQ-010 CLIP  out  1  one-cycle pulse, loaded sample was saturated.

Function
REQ-011 Divider counter runs 0..FREQ_DIV-1 and wraps to 0; tick is asserted in the cycle where counter == FREQ_DIV-1; FREQ_DIV=1 means tick every cycle.
REQ-012 Holding register plus full flag; SAMPLE_READY = !full || tick (combinational from registered state only, never from SAMPLE_VALID).
REQ-013 On transfer, SAMPLE is stored in the holding register and full is set.
REQ-014 On tick with full=1, the holding contents move to the active code and full clears, unless a transfer happens in the same cycle, in which case full stays 1 with the new sample.
REQ-015 On tick with full=0, the active code is unchanged (sample-and-hold, no underflow error).
REQ-016 Quantisation at load: 17-bit signed sum = SAMPLE + 2^(15-BIT_WIDTH), arithmetic shift right by (16-BIT_WIDTH), saturate to signed BIT_WIDTH range.
REQ-017 The saturated value is converted to offset binary (MSB inverted) to form the active code, range 0..2^BIT_WIDTH-1.
REQ-018 CLIP pulses high for exactly the cycle after a load where saturation occurred; otherwise 0.
REQ-019 Accumulator is BIT_WIDTH+1 bits; on each tick acc <= {1'b0, acc[BIT_WIDTH-1:0]} + code and DAC_OUT <= carry bit (acc[BIT_WIDTH] of the new sum).
REQ-020 DAC_OUT and acc change only on ticks; over 2^BIT_WIDTH ticks the count of DAC_OUT ones equals the code exactly.
REQ-021 When ENABLE=0: SAMPLE_READY forced 1; transfers are discarded; full is cleared; at the next tick the active code becomes 2^(BIT_WIDTH-1); CLIP stays 0.
REQ-022 The divider runs regardless of ENABLE; ENABLE rising takes effect from the next transfer.

Reset
REQ-023 While RESET_n=0 at a rising edge: counter=0, acc=0, full=0, active code=2^(BIT_WIDTH-1), DAC_OUT=0, CLIP=0; SAMPLE_READY=1 in the following cycle.
REQ-024 Reset asserted mid-stream discards any held sample and the accumulator residue with no partial-tick output; the first tick after release occurs FREQ_DIV cycles after release.

Verification (BIT_WIDTH=10, FREQ_DIV=5)
REQ-025 Reset, ENABLE=1, no samples -> ticks on cycles 4, 9, 14, ... after release; DAC_OUT sequence per tick 0,1,0,1,... (code 512).
REQ-026 SAMPLE=16'h7FFF accepted -> after load CLIP=1 for one cycle, code=1023, DAC_OUT has exactly 1023 ones per 1024 ticks; SAMPLE=16'h8000 -> code 0, CLIP=0, DAC_OUT constant 0.
REQ-027 SAMPLE=16'h0040 -> code 513, CLIP=0; SAMPLE=16'hFFE0 (-32) -> rounds to 0, code 512.
REQ-028 Two back-to-back valid samples A, B between ticks -> A accepted, SAMPLE_READY=0 next cycle, B held on the bus; on the tick A loads and B is accepted in the same cycle; A is never lost or duplicated.
REQ-029 ENABLE driven 0 with full=1 -> SAMPLE_READY=1, held sample dropped, code 512 after the next tick; ENABLE back to 1 with a new sample -> that sample plays.
REQ-030 RESET_n pulsed low for 1 cycle mid-stream with full=1 -> all REQ-023 values next cycle, SAMPLE_READY=1, first tick 5 cycles after release.
